// File: rtl/evt_sync_multi.sv
// Multi-channel asynchronous event synchronizer: per-channel CDC chain, stability
// filter, edge/level event detection and sticky pending/overflow flags.
module evt_sync_multi #(
  parameter int CH     = 4,
  parameter int STAGES = 2,
  parameter int FILT   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CH-1:0]     a_in,
  input  logic              en,
  input  logic [2*CH-1:0]   edge_sel,
  input  logic [CH-1:0]     ack,
  output logic [CH-1:0]     evt_pulse,
  output logic [CH-1:0]     evt_pend,
  output logic [CH-1:0]     evt_ovf
);

  localparam int              CW        = $clog2(FILT + 1);
  localparam logic [CW-1:0]   CNT_LAST  = CW'(FILT - 1);
  localparam logic [CW-1:0]   CNT_ONE   = CW'(1);
  localparam logic [1:0]      MODE_RISE = 2'b00;
  localparam logic [1:0]      MODE_FALL = 2'b01;
  localparam logic [1:0]      MODE_BOTH = 2'b10;
  localparam logic [1:0]      MODE_LVL  = 2'b11;

  logic [STAGES-1:0][CH-1:0]  sync_q, sync_d;
  logic [CH-1:0]              sync_s;
  logic [CH-1:0]              filt_q, filt_d;
  logic [CH-1:0]              filt_dly_q, filt_dly_d;
  logic [CH-1:0][CW-1:0]      cnt_q, cnt_d;
  logic [CH-1:0]              evt_pulse_q, evt_pulse_d;
  logic [CH-1:0]              evt_pend_q, evt_pend_d;
  logic [CH-1:0]              evt_ovf_q, evt_ovf_d;
  logic [CH-1:0]              evt_s;

  // Only the last synchronizer stage is allowed to feed logic.
  assign sync_s = sync_q[STAGES-1];

  // Next-state logic: shift chain, stability filter, event detect, sticky flags.
  always_comb begin
    sync_d      = {sync_q[STAGES-2:0], a_in};
    filt_d      = filt_q;
    filt_dly_d  = filt_q;
    cnt_d       = cnt_q;
    evt_s       = {CH{1'b0}};
    evt_pulse_d = {CH{1'b0}};
    evt_pend_d  = evt_pend_q;
    evt_ovf_d   = evt_ovf_q;

    for (int i = 0; i < CH; i++) begin
      if (sync_s[i] == filt_q[i]) begin
        cnt_d[i]  = {CW{1'b0}};
        filt_d[i] = filt_q[i];
      end else if (cnt_q[i] == CNT_LAST) begin
        cnt_d[i]  = {CW{1'b0}};
        filt_d[i] = sync_s[i];
      end else begin
        cnt_d[i]  = cnt_q[i] + CNT_ONE;
        filt_d[i] = filt_q[i];
      end

      case (edge_sel[2*i +: 2])
        MODE_RISE: evt_s[i] = filt_q[i] & ~filt_dly_q[i];
        MODE_FALL: evt_s[i] = ~filt_q[i] & filt_dly_q[i];
        MODE_BOTH: evt_s[i] = filt_q[i] ^ filt_dly_q[i];
        MODE_LVL:  evt_s[i] = filt_q[i];
        default:   evt_s[i] = 1'b0;
      endcase

      evt_pulse_d[i] = en & evt_s[i];

      // A new event always re-pends; a same-cycle ack only retires the older one.
      if (!en) begin
        evt_pend_d[i] = evt_pend_q[i];
        evt_ovf_d[i]  = evt_ovf_q[i];
      end else if (evt_pulse_d[i]) begin
        evt_pend_d[i] = 1'b1;
        if (ack[i]) begin
          evt_ovf_d[i] = 1'b0;
        end else if (evt_pend_q[i]) begin
          evt_ovf_d[i] = 1'b1;
        end else begin
          evt_ovf_d[i] = evt_ovf_q[i];
        end
      end else if (ack[i]) begin
        evt_pend_d[i] = 1'b0;
        evt_ovf_d[i]  = 1'b0;
      end else begin
        evt_pend_d[i] = evt_pend_q[i];
        evt_ovf_d[i]  = evt_ovf_q[i];
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q      <= '0;
      filt_q      <= {CH{1'b0}};
      filt_dly_q  <= {CH{1'b0}};
      cnt_q       <= '0;
      evt_pulse_q <= {CH{1'b0}};
      evt_pend_q  <= {CH{1'b0}};
      evt_ovf_q   <= {CH{1'b0}};
    end else begin
      sync_q      <= sync_d;
      filt_q      <= filt_d;
      filt_dly_q  <= filt_dly_d;
      cnt_q       <= cnt_d;
      evt_pulse_q <= evt_pulse_d;
      evt_pend_q  <= evt_pend_d;
      evt_ovf_q   <= evt_ovf_d;
    end
  end

  assign evt_pulse = evt_pulse_q;
  assign evt_pend  = evt_pend_q;
  assign evt_ovf   = evt_ovf_q;

endmodule

// File: tb/tb_evt_sync_multi.sv
// Scoreboard bench for evt_sync_multi: stimulus pushes cycle-stamped expectations,
// a negedge monitor pops and compares them.
module tb_evt_sync_multi;

  localparam int CH = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [CH-1:0]   a_in;
  logic            en;
  logic [2*CH-1:0] edge_sel;
  logic [CH-1:0]   ack;
  logic [CH-1:0]   evt_pulse, evt_pend, evt_ovf;

  typedef struct {
    int    cyc;
    int    ch;
    logic  p;
    logic  pe;
    logic  ov;
    string nm;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  evt_sync_multi #(.CH(CH), .STAGES(2), .FILT(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .a_in      (a_in),
    .en        (en),
    .edge_sel  (edge_sel),
    .ack       (ack),
    .evt_pulse (evt_pulse),
    .evt_pend  (evt_pend),
    .evt_ovf   (evt_ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every expectation due this cycle; anything overdue is a miss.
  always @(negedge clk) begin
    for (int k = sb.size() - 1; k >= 0; k--) begin
      if (sb[k].cyc == cyc) begin
        n_vec++;
        if (evt_pulse[sb[k].ch] !== sb[k].p || evt_pend[sb[k].ch] !== sb[k].pe ||
            evt_ovf[sb[k].ch] !== sb[k].ov) begin
          n_err++;
          $display("FAIL %s ch%0d cyc%0d: got pulse/pend/ovf=%b%b%b want %b%b%b",
                   sb[k].nm, sb[k].ch, cyc, evt_pulse[sb[k].ch], evt_pend[sb[k].ch],
                   evt_ovf[sb[k].ch], sb[k].p, sb[k].pe, sb[k].ov);
        end
        sb.delete(k);
      end else if (sb[k].cyc < cyc) begin
        n_vec++;
        n_err++;
        $display("FAIL %s ch%0d: expectation for cyc%0d never checked", sb[k].nm, sb[k].ch, sb[k].cyc);
        sb.delete(k);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect1(input int c, input string nm, input int ch,
                         input logic p, input logic pe, input logic ov);
    exp_t e;
    e.cyc = c; e.ch = ch; e.p = p; e.pe = pe; e.ov = ov; e.nm = nm;
    sb.push_back(e);
  endtask

  task automatic expect_quiet(input int c0, input int c1, input string nm, input int ch);
    for (int c = c0; c <= c1; c++) expect1(c, nm, ch, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_ack(input int ch);
    int n;
    n = cyc;
    expect1(n + 1, "ack_clear", ch, 1'b0, 1'b0, 1'b0);
    ack[ch] = 1'b1;
    tick(1);
    ack[ch] = 1'b0;
  endtask

  initial begin
    int b, b2, guard;
    rst = 1'b1; a_in = 4'b0001; en = 1'b1; edge_sel = 8'h00; ack = 4'b0000;

    // Reset state, then ch0 held high through reset release.
    tick(3);
    for (int ch = 0; ch < CH; ch++) expect1(cyc, "reset_state", ch, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    b = cyc;
    expect1(b + 5, "rst_rel_pre", 0, 1'b0, 1'b0, 1'b0);
    expect1(b + 6, "rst_rel_pulse", 0, 1'b1, 1'b1, 1'b0);
    expect1(b + 7, "rst_rel_end", 0, 1'b0, 1'b1, 1'b0);
    tick(8);
    do_ack(0);

    // Basic rise on ch0: falling edge ignored in rise mode, then 0->1.
    a_in[0] = 1'b0;
    tick(8);
    b = cyc;
    a_in[0] = 1'b1;
    expect1(b + 5, "rise_pre", 0, 1'b0, 1'b0, 1'b0);
    expect1(b + 6, "rise_pulse", 0, 1'b1, 1'b1, 1'b0);
    expect1(b + 7, "rise_end", 0, 1'b0, 1'b1, 1'b0);
    tick(8);
    do_ack(0);

    // Glitch rejection on ch1 in both mode, then a 5-cycle pulse.
    edge_sel[3:2] = 2'b10;
    b = cyc;
    expect_quiet(b + 1, b + 12, "glitch", 1);
    a_in[1] = 1'b1;
    tick(2);
    a_in[1] = 1'b0;
    tick(12);
    b = cyc;
    expect1(b + 6, "both_rise", 1, 1'b1, 1'b1, 1'b0);
    expect1(b + 7, "both_rise_end", 1, 1'b0, 1'b1, 1'b0);
    expect1(b + 11, "both_fall", 1, 1'b1, 1'b1, 1'b1);
    expect1(b + 12, "both_fall_end", 1, 1'b0, 1'b1, 1'b1);
    a_in[1] = 1'b1;
    tick(5);
    a_in[1] = 1'b0;
    tick(9);
    do_ack(1);

    // Overflow on ch2: two rises without ack.
    b = cyc;
    expect1(b + 6, "ovf_first", 2, 1'b1, 1'b1, 1'b0);
    a_in[2] = 1'b1;
    tick(8);
    a_in[2] = 1'b0;
    tick(8);
    b2 = cyc;
    expect1(b2 + 5, "ovf_pre", 2, 1'b0, 1'b1, 1'b0);
    expect1(b2 + 6, "ovf_second", 2, 1'b1, 1'b1, 1'b1);
    expect1(b2 + 7, "ovf_hold", 2, 1'b0, 1'b1, 1'b1);
    a_in[2] = 1'b1;
    tick(10);
    do_ack(2);

    // Collision on ch3 (both mode): overflow first, then event+ack same cycle.
    edge_sel[7:6] = 2'b10;
    b = cyc;
    expect_quiet(b + 1, b + 3, "mode_chg", 3);
    expect1(b + 6, "col_rise", 3, 1'b1, 1'b1, 1'b0);
    expect1(b + 11, "col_fall_ovf", 3, 1'b1, 1'b1, 1'b1);
    a_in[3] = 1'b1;
    tick(5);
    a_in[3] = 1'b0;
    tick(9);
    b2 = cyc;
    expect1(b2 + 6, "collision", 3, 1'b1, 1'b1, 1'b0);
    expect1(b2 + 7, "collision_after", 3, 1'b0, 1'b1, 1'b0);
    a_in[3] = 1'b1;
    tick(5);
    ack[3] = 1'b1;
    tick(1);
    ack[3] = 1'b0;
    tick(4);

    // Level mode on ch0 with ack every cycle.
    a_in[0] = 1'b0;
    tick(8);
    edge_sel[1:0] = 2'b11;
    b = cyc;
    expect_quiet(b + 1, b + 3, "lvl_idle", 0);
    for (int c = b + 6; c <= b + 17; c++) expect1(c, "lvl_high", 0, 1'b1, 1'b1, 1'b0);
    expect1(b + 18, "lvl_drop", 0, 1'b0, 1'b0, 1'b0);
    a_in[0] = 1'b1;
    tick(6);
    ack[0] = 1'b1;
    tick(6);
    a_in[0] = 1'b0;
    tick(7);
    ack[0] = 1'b0;
    edge_sel[1:0] = 2'b00;

    // Reset mid-filter on ch0 and mid-pending on ch3.
    a_in = 4'b0000;
    tick(10);
    b = cyc;
    a_in[0] = 1'b1;
    tick(3);
    rst = 1'b1;
    a_in[0] = 1'b0;
    for (int ch = 0; ch < CH; ch++) expect1(b + 4, "rst_mid", ch, 1'b0, 1'b0, 1'b0);
    expect_quiet(b + 5, b + 12, "rst_no_evt", 0);
    tick(1);
    rst = 1'b0;
    tick(10);

    // Enable low during a ch1 transition: event lost, filter still tracks.
    b = cyc;
    en = 1'b0;
    a_in[1] = 1'b1;
    expect_quiet(b + 1, b + 12, "en_off", 1);
    tick(8);
    en = 1'b1;
    tick(4);
    b2 = cyc;
    expect1(b2 + 6, "en_filt_fall", 1, 1'b1, 1'b1, 1'b0);
    expect1(b2 + 7, "en_filt_end", 1, 1'b0, 1'b1, 1'b0);
    a_in[1] = 1'b0;
    tick(10);

    guard = 0;
    while (sb.size() > 0 && guard < 50) begin
      tick(1);
      guard++;
    end
    if (sb.size() > 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: %0d expectations left unchecked", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
